// File: rtl/axi_master_arbiter.sv
// Shares one AXI3 master port between NUM_RD round-robin read clients and a single write client.
// Define AXI_ARB_RAW_CHECK_EN to hold back reads that hit the line of an in-flight write.

module axi_master_arbiter #(
  parameter int NUM_RD      = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LINE_OFFSET = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_RD-1:0]              rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  input  logic [NUM_RD*8-1:0]            rd_len,
  input  logic [NUM_RD*3-1:0]            rd_size,
  output logic [NUM_RD-1:0]              rd_gnt,
  output logic [NUM_RD-1:0]              rd_data_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_last,
  output logic                           rd_err,
  input  logic                           wr_req,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [7:0]                     wr_len,
  input  logic [2:0]                     wr_size,
  output logic                           wr_gnt,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic                           wr_data_valid,
  output logic                           wr_data_ready,
  output logic                           wr_done,
  output logic                           wr_err,
  output logic [3:0]                     arid,
  output logic [ADDR_WIDTH-1:0]          araddr,
  output logic [7:0]                     arlen,
  output logic [2:0]                     arsize,
  output logic [1:0]                     arburst,
  output logic [1:0]                     arlock,
  output logic [3:0]                     arcache,
  output logic [2:0]                     arprot,
  output logic                           arvalid,
  input  logic                           arready,
  input  logic [3:0]                     rid,
  input  logic [DATA_WIDTH-1:0]          rdata,
  input  logic [1:0]                     rresp,
  input  logic                           rlast,
  input  logic                           rvalid,
  output logic                           rready,
  output logic [3:0]                     awid,
  output logic [ADDR_WIDTH-1:0]          awaddr,
  output logic [7:0]                     awlen,
  output logic [2:0]                     awsize,
  output logic [1:0]                     awburst,
  output logic [1:0]                     awlock,
  output logic [3:0]                     awcache,
  output logic [2:0]                     awprot,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [3:0]                     wid,
  output logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic                           wlast,
  output logic                           wvalid,
  input  logic                           wready,
  input  logic [3:0]                     bid,
  input  logic [1:0]                     bresp,
  input  logic                           bvalid,
  output logic                           bready
);

  localparam int IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t              r_state, r_next;
  wr_state_t              w_state, w_next;
  logic [IW-1:0]          rr_ptr, owner, winner;
  logic                   win_found, beat_ok;
  logic [NUM_RD-1:0]      raw_block;
  logic [ADDR_WIDTH-1:0]  ar_addr_q, aw_addr_q;
  logic [7:0]             ar_len_q, aw_len_q, beat_cnt;
  logic [2:0]             ar_size_q, aw_size_q;
  logic                   w_beat, w_final;
  logic                   unused_bits;

  assign unused_bits = ^{rresp[0], bresp[0], bid};

`ifdef AXI_ARB_RAW_CHECK_EN
  // A read to the line of a write still in flight must wait until that write completes.
  always_comb begin
    raw_block = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (w_state != W_IDLE &&
          rd_addr[i*ADDR_WIDTH+LINE_OFFSET +: ADDR_WIDTH-LINE_OFFSET] == aw_addr_q[ADDR_WIDTH-1:LINE_OFFSET])
        raw_block[i] = 1'b1;
    end
  end
`else
  assign raw_block = '0;
`endif

  // Scan clients starting at the round-robin pointer; first eligible requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    winner    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_RD;
      if (!win_found && rd_req[idx] && !raw_block[idx]) begin
        win_found = 1'b1;
        winner    = IW'(idx);
      end
    end
  end

  assign beat_ok = rvalid && (rid == 4'(owner));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (win_found) r_next = R_ADDR;
      R_ADDR:  if (arready) r_next = R_DATA;
      R_DATA:  if (beat_ok && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_gnt        = '0;
    rd_data_valid = '0;
    rd_data       = '0;
    rd_last       = 1'b0;
    rd_err        = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    case (r_state)
      R_IDLE: if (win_found && aresetn) rd_gnt[winner] = 1'b1;
      R_ADDR: arvalid = 1'b1;
      R_DATA: begin
        rready = 1'b1;
        if (beat_ok) begin
          rd_data_valid[owner] = 1'b1;
          rd_data              = rdata;
          rd_last              = rlast;
          rd_err               = rresp[1];
        end
      end
      default: ;
    endcase
  end

  // The granted client drops to lowest priority for the next arbitration.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      owner     <= '0;
      rr_ptr    <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
    end else if (r_state == R_IDLE && win_found) begin
      owner     <= winner;
      ar_addr_q <= rd_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
      ar_len_q  <= rd_len[winner*8 +: 8];
      ar_size_q <= rd_size[winner*3 +: 3];
      if (int'(winner) == NUM_RD-1) rr_ptr <= '0;
      else                          rr_ptr <= winner + 1'b1;
    end
  end

  assign arid    = 4'(owner);
  assign araddr  = ar_addr_q;
  assign arlen   = ar_len_q;
  assign arsize  = ar_size_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign w_beat  = (w_state == W_DATA) && wr_data_valid && wready;
  assign w_final = w_beat && (beat_cnt == aw_len_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_req) w_next = W_ADDR;
      W_ADDR:  if (awready) w_next = W_DATA;
      W_DATA:  if (w_final) w_next = W_RESP;
      W_RESP:  if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    wr_gnt        = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    wr_data_ready = 1'b0;
    wdata         = '0;
    wstrb         = '0;
    wlast         = 1'b0;
    bready        = 1'b0;
    case (w_state)
      W_IDLE: wr_gnt = wr_req && aresetn;
      W_ADDR: awvalid = 1'b1;
      W_DATA: begin
        wvalid        = wr_data_valid;
        wr_data_ready = wready;
        wdata         = wr_data;
        wstrb         = wr_strb;
        wlast         = (beat_cnt == aw_len_q);
      end
      W_RESP: bready = 1'b1;
      default: ;
    endcase
  end

  // Completion is reported the cycle after the B handshake, with its error flag alongside.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      beat_cnt  <= '0;
      wr_done   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_done <= (w_state == W_RESP) && bvalid;
      wr_err  <= (w_state == W_RESP) && bvalid && bresp[1];
      if (w_state == W_IDLE && wr_req) begin
        aw_addr_q <= wr_addr;
        aw_len_q  <= wr_len;
        aw_size_q <= wr_size;
        beat_cnt  <= '0;
      end else if (w_beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  assign awid    = 4'd1;
  assign wid     = 4'd1;
  assign awaddr  = aw_addr_q;
  assign awlen   = aw_len_q;
  assign awsize  = aw_size_q;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed testbench for axi_master_arbiter; the bench plays the AXI slave and drives/samples on the falling edge.
// Scenarios adapt to AXI_ARB_RAW_CHECK_EN when it is defined.

module tb_axi_master_arbiter;

  logic        aclk, aresetn;
  logic [1:0]  rd_req;
  logic [63:0] rd_addr;
  logic [15:0] rd_len;
  logic [5:0]  rd_size;
  logic [1:0]  rd_gnt, rd_data_valid;
  logic [31:0] rd_data;
  logic        rd_last, rd_err;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len;
  logic [2:0]  wr_size;
  logic        wr_gnt;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_data_valid, wr_data_ready, wr_done, wr_err;
  logic [3:0]  arid, arcache, rid, awid, awcache, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int total = 0;
  int bad   = 0;

  axi_master_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_size(rd_size),
    .rd_gnt(rd_gnt), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .rd_last(rd_last), .rd_err(rd_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_size(wr_size), .wr_gnt(wr_gnt),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .wr_done(wr_done), .wr_err(wr_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic clear_inputs();
    rd_req = '0; rd_addr = '0; rd_len = '0; rd_size = '0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_size = '0;
    wr_data = '0; wr_strb = '0; wr_data_valid = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    clear_inputs();
    rd_req = 2'b11;
    wr_req = 1'b1;
    @(negedge aclk); #1;
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("[TB] FAIL rst_rd_gnt got=%b exp=00", rd_gnt); end
    total++; if (wr_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr_gnt got=%b exp=0", wr_gnt); end
    total++; if (arvalid !== 1'b0 || awvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_avalid got=%b%b exp=00", arvalid, awvalid); end
    total++; if (rready !== 1'b0 || bready !== 1'b0 || wvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_handshake got=%b%b%b exp=000", rready, bready, wvalid); end
    total++; if (wr_done !== 1'b0 || wr_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr_done got=%b%b exp=00", wr_done, wr_err); end
    total++; if (araddr !== 32'h0 || arid !== 4'h0) begin bad++; $display("[TB] FAIL rst_ar_fields got=%h/%h exp=0/0", araddr, arid); end
    rd_req = 2'b00;
    wr_req = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk); #1;
    total++; if (arvalid !== 1'b0 || rd_data_valid !== 2'b00) begin bad++; $display("[TB] FAIL idle_after_rst got=%b/%b exp=0/00", arvalid, rd_data_valid); end
  endtask

  task automatic test_read_single();
    do_reset();
    @(negedge aclk);
    rd_req = 2'b01; rd_addr[31:0] = 32'h1C00_0000; rd_len[7:0] = 8'd3; rd_size[2:0] = 3'd2;
    #1;
    total++; if (rd_gnt !== 2'b01) begin bad++; $display("[TB] FAIL rd1_gnt got=%b exp=01", rd_gnt); end
    @(negedge aclk);
    rd_req = 2'b00; arready = 1'b1;
    #1;
    total++; if (arvalid !== 1'b1) begin bad++; $display("[TB] FAIL rd1_arvalid got=%b exp=1", arvalid); end
    total++; if (araddr !== 32'h1C00_0000 || arlen !== 8'd3 || arsize !== 3'd2) begin bad++; $display("[TB] FAIL rd1_ar got=%h/%0d/%0d exp=1c000000/3/2", araddr, arlen, arsize); end
    total++; if (arid !== 4'd0 || arburst !== 2'b01) begin bad++; $display("[TB] FAIL rd1_arid got=%0d/%b exp=0/01", arid, arburst); end
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rresp = 2'b00;
      rdata = 32'hA000_0000 + 32'(i); rlast = (i == 3);
      #1;
      total++; if (rd_data_valid !== 2'b01) begin bad++; $display("[TB] FAIL rd1_valid beat=%0d got=%b exp=01", i, rd_data_valid); end
      total++; if (rd_data !== 32'hA000_0000 + 32'(i)) begin bad++; $display("[TB] FAIL rd1_data beat=%0d got=%h exp=%h", i, rd_data, 32'hA000_0000 + 32'(i)); end
      total++; if (rd_last !== (i == 3)) begin bad++; $display("[TB] FAIL rd1_last beat=%0d got=%b exp=%b", i, rd_last, (i == 3)); end
    end
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    total++; if (rready !== 1'b0 || rd_data_valid !== 2'b00) begin bad++; $display("[TB] FAIL rd1_idle got=%b/%b exp=0/00", rready, rd_data_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [3];
    logic [3:0] exp_id;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    do_reset();
    rd_addr = {32'h0000_2000, 32'h0000_1000};
    rd_len  = 16'h0000;
    for (int b = 0; b < 3; b++) begin
      exp_id = exp_g[b][1] ? 4'd1 : 4'd0;
      @(negedge aclk);
      rd_req = 2'b11; rvalid = 1'b0; rlast = 1'b0;
      #1;
      total++; if (rd_gnt !== exp_g[b]) begin bad++; $display("[TB] FAIL rr_gnt burst=%0d got=%b exp=%b", b, rd_gnt, exp_g[b]); end
      @(negedge aclk);
      arready = 1'b1;
      #1;
      total++; if (arvalid !== 1'b1 || arid !== exp_id || rd_gnt !== 2'b00) begin bad++; $display("[TB] FAIL rr_ar burst=%0d got=%b/%0d/%b exp=1/%0d/00", b, arvalid, arid, rd_gnt, exp_id); end
      @(negedge aclk);
      arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = exp_id; rdata = 32'h5555_0000 + 32'(b);
      #1;
      total++; if (rd_data_valid !== exp_g[b] || rd_last !== 1'b1) begin bad++; $display("[TB] FAIL rr_beat burst=%0d got=%b/%b exp=%b/1", b, rd_data_valid, rd_last, exp_g[b]); end
    end
    @(negedge aclk);
    rd_req = 2'b00; rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_write();
    @(negedge aclk);
    wr_req = 1'b1; wr_addr = 32'h0000_1000; wr_len = 8'd1; wr_size = 3'd2;
    #1;
    total++; if (wr_gnt !== 1'b1) begin bad++; $display("[TB] FAIL wr_gnt got=%b exp=1", wr_gnt); end
    @(negedge aclk);
    wr_req = 1'b0; awready = 1'b1;
    #1;
    total++; if (awvalid !== 1'b1 || awaddr !== 32'h0000_1000 || awlen !== 8'd1 || awid !== 4'd1) begin bad++; $display("[TB] FAIL wr_aw got=%b/%h/%0d/%0d exp=1/00001000/1/1", awvalid, awaddr, awlen, awid); end
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      awready = 1'b0; wr_data_valid = 1'b1; wr_data = 32'hD000_0000; wr_strb = 4'hF; wready = 1'b0;
      #1;
      total++; if (wvalid !== 1'b1 || wlast !== 1'b0 || wr_data_ready !== 1'b0) begin bad++; $display("[TB] FAIL wr_stall cyc=%0d got=%b%b%b exp=100", c, wvalid, wlast, wr_data_ready); end
    end
    @(negedge aclk);
    wready = 1'b1;
    #1;
    total++; if (wlast !== 1'b0 || wr_data_ready !== 1'b1 || wdata !== 32'hD000_0000 || wid !== 4'd1) begin bad++; $display("[TB] FAIL wr_beat1 got=%b/%b/%h/%0d exp=0/1/d0000000/1", wlast, wr_data_ready, wdata, wid); end
    @(negedge aclk);
    wr_data = 32'hD000_0001; wr_strb = 4'h3;
    #1;
    total++; if (wlast !== 1'b1 || wdata !== 32'hD000_0001 || wstrb !== 4'h3) begin bad++; $display("[TB] FAIL wr_beat2 got=%b/%h/%h exp=1/d0000001/3", wlast, wdata, wstrb); end
    @(negedge aclk);
    wr_data_valid = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10; bid = 4'd1;
    #1;
    total++; if (bready !== 1'b1 || wr_done !== 1'b0 || wvalid !== 1'b0) begin bad++; $display("[TB] FAIL wr_resp got=%b/%b/%b exp=1/0/0", bready, wr_done, wvalid); end
    @(negedge aclk);
    bvalid = 1'b0; bresp = 2'b00;
    #1;
    total++; if (wr_done !== 1'b1 || wr_err !== 1'b1 || bready !== 1'b0) begin bad++; $display("[TB] FAIL wr_done got=%b/%b/%b exp=1/1/0", wr_done, wr_err, bready); end
    @(negedge aclk); #1;
    total++; if (wr_done !== 1'b0 || wr_err !== 1'b0) begin bad++; $display("[TB] FAIL wr_done_pulse got=%b/%b exp=0/0", wr_done, wr_err); end
  endtask

  task automatic test_read_error();
    @(negedge aclk);
    rd_req = 2'b10; rd_addr[63:32] = 32'h0000_3000; rd_len[15:8] = 8'd2;
    #1;
    total++; if (rd_gnt !== 2'b10) begin bad++; $display("[TB] FAIL re_gnt got=%b exp=10", rd_gnt); end
    @(negedge aclk);
    rd_req = 2'b00; arready = 1'b1;
    #1;
    total++; if (arid !== 4'd1 || arlen !== 8'd2) begin bad++; $display("[TB] FAIL re_ar got=%0d/%0d exp=1/2", arid, arlen); end
    @(negedge aclk);
    arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rresp = 2'b00; rdata = 32'h0000_0B00;
    #1;
    total++; if (rd_data_valid !== 2'b10 || rd_err !== 1'b0) begin bad++; $display("[TB] FAIL re_beat1 got=%b/%b exp=10/0", rd_data_valid, rd_err); end
    @(negedge aclk);
    rid = 4'd0; rresp = 2'b10;
    #1;
    total++; if (rd_data_valid !== 2'b00 || rready !== 1'b1 || rd_err !== 1'b0) begin bad++; $display("[TB] FAIL re_foreign got=%b/%b/%b exp=00/1/0", rd_data_valid, rready, rd_err); end
    @(negedge aclk);
    rid = 4'd1; rresp = 2'b10; rdata = 32'h0000_0B01;
    #1;
    total++; if (rd_data_valid !== 2'b10 || rd_err !== 1'b1 || rd_last !== 1'b0) begin bad++; $display("[TB] FAIL re_beat2 got=%b/%b/%b exp=10/1/0", rd_data_valid, rd_err, rd_last); end
    @(negedge aclk);
    rresp = 2'b00; rlast = 1'b1; rdata = 32'h0000_0B02;
    #1;
    total++; if (rd_err !== 1'b0 || rd_last !== 1'b1 || rd_data !== 32'h0000_0B02) begin bad++; $display("[TB] FAIL re_beat3 got=%b/%b/%h exp=0/1/00000b02", rd_err, rd_last, rd_data); end
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    total++; if (rready !== 1'b0) begin bad++; $display("[TB] FAIL re_idle got=%b exp=0", rready); end
  endtask

  task automatic test_reset_midburst();
    @(negedge aclk);
    rd_req = 2'b01; rd_addr[31:0] = 32'h1C00_0040; rd_len[7:0] = 8'd3;
    @(negedge aclk);
    rd_req = 2'b00; arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_C000;
    @(negedge aclk);
    rdata = 32'h0000_C001;
    #1;
    total++; if (rd_data_valid !== 2'b01) begin bad++; $display("[TB] FAIL mr_pre got=%b exp=01", rd_data_valid); end
    #1 aresetn = 1'b0;
    #1;
    total++; if (rd_data_valid !== 2'b00 || rready !== 1'b0 || rd_data !== 32'h0) begin bad++; $display("[TB] FAIL mr_async got=%b/%b/%h exp=00/0/0", rd_data_valid, rready, rd_data); end
    total++; if (araddr !== 32'h0 || arvalid !== 1'b0) begin bad++; $display("[TB] FAIL mr_ar got=%h/%b exp=0/0", araddr, arvalid); end
    @(negedge aclk);
    clear_inputs();
    aresetn = 1'b1;
    @(negedge aclk);
    rd_req = 2'b10; rd_addr[63:32] = 32'h2000_0000;
    #1;
    total++; if (rd_gnt !== 2'b10) begin bad++; $display("[TB] FAIL mr_gnt got=%b exp=10", rd_gnt); end
    @(negedge aclk);
    rd_req = 2'b00; arready = 1'b1;
    #1;
    total++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h2000_0000) begin bad++; $display("[TB] FAIL mr_ar2 got=%b/%0d/%h exp=1/1/20000000", arvalid, arid, araddr); end
    @(negedge aclk);
    arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rlast = 1'b1;
    #1;
    total++; if (rd_data_valid !== 2'b10 || rd_last !== 1'b1) begin bad++; $display("[TB] FAIL mr_beat got=%b/%b exp=10/1", rd_data_valid, rd_last); end
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_raw();
    @(negedge aclk);
    wr_req = 1'b1; wr_addr = 32'h0000_1000; wr_len = 8'd0;
    @(negedge aclk);
    wr_req = 1'b0; awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0; wr_data_valid = 1'b1; wready = 1'b1;
    #1;
    total++; if (wlast !== 1'b1) begin bad++; $display("[TB] FAIL raw_wlast got=%b exp=1", wlast); end
    @(negedge aclk);
    wr_data_valid = 1'b0; wready = 1'b0;
    rd_req = 2'b01; rd_addr[31:0] = 32'h0000_1008; rd_len[7:0] = 8'd0;
    #1;
`ifdef AXI_ARB_RAW_CHECK_EN
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("[TB] FAIL raw_block1 got=%b exp=00", rd_gnt); end
    @(negedge aclk);
    bvalid = 1'b1;
    #1;
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("[TB] FAIL raw_block2 got=%b exp=00", rd_gnt); end
    @(negedge aclk);
    bvalid = 1'b0;
    #1;
    total++; if (rd_gnt !== 2'b01 || wr_done !== 1'b1) begin bad++; $display("[TB] FAIL raw_release got=%b/%b exp=01/1", rd_gnt, wr_done); end
    @(negedge aclk);
    rd_req = 2'b00; arready = 1'b1;
    #1;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h0000_1008) begin bad++; $display("[TB] FAIL raw_ar got=%b/%h exp=1/00001008", arvalid, araddr); end
    @(negedge aclk);
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rlast = 1'b1;
    #1;
    total++; if (rd_data_valid !== 2'b01) begin bad++; $display("[TB] FAIL raw_beat got=%b exp=01", rd_data_valid); end
`else
    total++; if (rd_gnt !== 2'b01) begin bad++; $display("[TB] FAIL raw_free_gnt got=%b exp=01", rd_gnt); end
    @(negedge aclk);
    rd_req = 2'b00; arready = 1'b1; bvalid = 1'b1;
    #1;
    total++; if (arvalid !== 1'b1 || bready !== 1'b1) begin bad++; $display("[TB] FAIL raw_concurrent got=%b/%b exp=1/1", arvalid, bready); end
    @(negedge aclk);
    arready = 1'b0; bvalid = 1'b0; rvalid = 1'b1; rid = 4'd0; rlast = 1'b1;
    #1;
    total++; if (rd_data_valid !== 2'b01 || wr_done !== 1'b1) begin bad++; $display("[TB] FAIL raw_finish got=%b/%b exp=01/1", rd_data_valid, wr_done); end
`endif
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_round_robin();
    test_write();
    test_read_error();
    test_reset_midburst();
    test_raw();
    repeat (2) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
